// File: rtl/dll_alu_pkg.sv
// Shared types, counter width and output clamp helper for the DLL delay-code controller.
package dll_alu_pkg;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      UP   = 2'd1,
      DN   = 2'd2
   } dir_t;

   typedef logic [0:0] state_t;
   localparam state_t ACQUIRE = 1'b0;
   localparam state_t LOCKED  = 1'b1;

   localparam int unsigned CNT_W = 4;

   function automatic int clamp(input int val, input int lo, input int hi);
      if (val < lo) return lo;
      if (val > hi) return hi;
      return val;
   endfunction

endpackage

// File: rtl/dll_alu_chan.sv
// One DLL channel: saturating delay code, acquire/locked FSM with hysteresis,
// and the offset-adjusted, update-gated output register.
module dll_alu_chan
   import dll_alu_pkg::*;
#(
   parameter int unsigned CODE_W           = 9,
   parameter int unsigned CODE_INIT        = 2 ** (CODE_W - 1),
   parameter int unsigned ALU_LOCK_CNT     = 3,
   parameter int unsigned ALU_UNLOCK_CNT   = 3,
   parameter int unsigned GLITCH_TOLERANCE = 0,
   parameter int          DCNTL_ADJVAL     = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pd_valid,
   input  logic              pd_up,
   input  logic              pd_dn,
   input  logic              aluhold,
   input  logic              uddcntl,
   output logic [CODE_W-1:0] dcntl,
   output logic              lock,
   output logic              code_sat
);

   localparam int unsigned       SUM_W      = CODE_W + 2;
   localparam int                CODE_HI    = (2 ** CODE_W) - 1;
   localparam logic [CODE_W-1:0] CODE_MAX   = '1;
   localparam logic [CNT_W-1:0]  LOCK_TGT   = CNT_W'(ALU_LOCK_CNT);
   localparam logic [CNT_W-1:0]  UNLOCK_TGT = CNT_W'(ALU_UNLOCK_CNT);
   localparam logic [CNT_W-1:0]  GLITCH_TOL = CNT_W'(GLITCH_TOLERANCE);

   state_t                   state_q, state_d;
   dir_t                     prev_q, prev_d;
   logic [CODE_W-1:0]        code_q, code_d;
   logic                     sat_d;
   logic [CNT_W-1:0]         good_q, good_d;
   logic [CNT_W-1:0]         run_q, run_d;
   logic [CNT_W-1:0]         bad_q, bad_d;
   dir_t                     dir_c;
   logic                     sample_c;
   logic                     sat_step_c;
   logic                     same_c;
   logic signed [SUM_W-1:0]  sum_c;

   // Sample decode; a pinned step or the first step after reset counts as same-direction.
   always_comb begin : decode
      sample_c = pd_valid && !aluhold;
      dir_c    = NONE;
      if (pd_up && !pd_dn)
         dir_c = UP;
      else if (pd_dn && !pd_up)
         dir_c = DN;
      sat_step_c = ((dir_c == UP) && (code_q == CODE_MAX)) ||
                   ((dir_c == DN) && (code_q == '0));
      same_c     = (dir_c != NONE) &&
                   (sat_step_c || (prev_q == NONE) || (prev_q == dir_c));
      sum_c      = $signed({2'b00, code_q}) + SUM_W'(DCNTL_ADJVAL);
   end

   always_comb begin : next_state
      state_d = state_q;
      prev_d  = prev_q;
      code_d  = code_q;
      sat_d   = code_sat;
      good_d  = good_q;
      run_d   = run_q;
      bad_d   = bad_q;
      if (sample_c) begin
         sat_d = sat_step_c;
         if (!sat_step_c) begin
            if (dir_c == UP)
               code_d = code_q + CODE_W'(1);
            else if (dir_c == DN)
               code_d = code_q - CODE_W'(1);
         end
         if (dir_c != NONE)
            prev_d = dir_c;
         if (state_q == ACQUIRE) begin
            if (same_c) begin
               good_d = '0;
            end else if ((good_q + CNT_W'(1)) == LOCK_TGT) begin
               state_d = LOCKED;
               good_d  = '0;
               run_d   = '0;
               bad_d   = '0;
            end else begin
               good_d = good_q + CNT_W'(1);
            end
         end else begin
            if (!same_c) begin
               run_d = '0;
               bad_d = '0;
            end else begin
               if (run_q != '1)
                  run_d = run_q + CNT_W'(1);
               // The step that takes run_len past the tolerance is the first counted one.
               if (run_q >= GLITCH_TOL) begin
                  if ((bad_q + CNT_W'(1)) == UNLOCK_TGT) begin
                     state_d = ACQUIRE;
                     good_d  = '0;
                     run_d   = '0;
                     bad_d   = '0;
                  end else begin
                     bad_d = bad_q + CNT_W'(1);
                  end
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin : regs
      if (rst) begin
         state_q  <= ACQUIRE;
         prev_q   <= NONE;
         code_q   <= CODE_W'(CODE_INIT);
         code_sat <= 1'b0;
         good_q   <= '0;
         run_q    <= '0;
         bad_q    <= '0;
         lock     <= 1'b0;
         dcntl    <= '0;
      end else begin
         state_q  <= state_d;
         prev_q   <= prev_d;
         code_q   <= code_d;
         code_sat <= sat_d;
         good_q   <= good_d;
         run_q    <= run_d;
         bad_q    <= bad_d;
         lock     <= (state_d == LOCKED);
         if (uddcntl)
            dcntl <= CODE_W'(clamp(int'(sum_c), 0, CODE_HI));
      end
   end

endmodule

// File: rtl/dll_alu_ctrl.sv
// Multi-channel DLL delay-code controller: one dll_alu_chan per channel,
// packed DCNTL bus and an aggregate lock flag.
module dll_alu_ctrl
   import dll_alu_pkg::*;
#(
   parameter int unsigned NCH              = 1,
   parameter int unsigned CODE_W           = 9,
   parameter int unsigned CODE_INIT        = 2 ** (CODE_W - 1),
   parameter int unsigned ALU_LOCK_CNT     = 3,
   parameter int unsigned ALU_UNLOCK_CNT   = 3,
   parameter int unsigned GLITCH_TOLERANCE = 0,
   parameter int          DCNTL_ADJVAL     = 0
) (
   input  logic                  CLKI,
   input  logic                  RST,
   input  logic [NCH-1:0]        PD_VALID,
   input  logic [NCH-1:0]        PD_UP,
   input  logic [NCH-1:0]        PD_DN,
   input  logic                  ALUHOLD,
   input  logic                  UDDCNTL,
   output logic [NCH*CODE_W-1:0] DCNTL,
   output logic [NCH-1:0]        LOCK,
   output logic                  LOCK_ALL,
   output logic [NCH-1:0]        CODE_SAT
);

   for (genvar i = 0; i < NCH; i++) begin : g_chan
      dll_alu_chan #(
         .CODE_W           (CODE_W),
         .CODE_INIT        (CODE_INIT),
         .ALU_LOCK_CNT     (ALU_LOCK_CNT),
         .ALU_UNLOCK_CNT   (ALU_UNLOCK_CNT),
         .GLITCH_TOLERANCE (GLITCH_TOLERANCE),
         .DCNTL_ADJVAL     (DCNTL_ADJVAL)
      ) u_chan (
         .clk      (CLKI),
         .rst      (RST),
         .pd_valid (PD_VALID[i]),
         .pd_up    (PD_UP[i]),
         .pd_dn    (PD_DN[i]),
         .aluhold  (ALUHOLD),
         .uddcntl  (UDDCNTL),
         .dcntl    (DCNTL[i*CODE_W +: CODE_W]),
         .lock     (LOCK[i]),
         .code_sat (CODE_SAT[i])
      );
   end

   // Decoded straight from the registered per-channel locks.
   assign LOCK_ALL = &LOCK;

endmodule
